// File: rtl/chip8_pkg.sv
// Shared geometry, scan-state type and pixel addressing for the CHIP-8 display path.
package chip8_pkg;

  localparam int unsigned SCREEN_W        = 64;
  localparam int unsigned SCREEN_H        = 32;
  localparam int unsigned FB_BITS         = SCREEN_W * SCREEN_H;
  localparam int unsigned BEATS_PER_ROW   = SCREEN_W / 8;
  localparam int unsigned BEATS_PER_FRAME = FB_BITS / 8;

  typedef enum logic [0:0] {
    SCAN_IDLE   = 1'b0,
    SCAN_STREAM = 1'b1
  } scan_state_e;

  // Pixel (x,y) lives at bit y*64+x; with a 64-wide screen that is a plain concatenation.
  function automatic logic [10:0] fb_bit_index(input logic [5:0] x, input logic [4:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/chip8_fb_byte_sel.sv
// Picks the eight pixels of one beat out of the framebuffer and puts the leftmost in bit 7.
module chip8_fb_byte_sel
  import chip8_pkg::*;
(
  input  logic [FB_BITS-1:0] fb,
  input  logic [7:0]         beat,
  output logic [7:0]         data
);

  logic [10:0] base;
  logic [7:0]  grp;

  // Beat b covers row b[7:3], columns b[2:0]*8 .. b[2:0]*8+7.
  assign base = fb_bit_index({beat[2:0], 3'b000}, beat[7:3]);
  assign grp  = fb[base +: 8];

  // Bit-reverse so the lowest x (leftmost pixel) lands in the MSB.
  always_comb begin
    data = '0;
    for (int k = 0; k < 8; k++) begin
      data[7-k] = grp[k];
    end
  end

endmodule

// File: rtl/chip8_display_scan.sv
// Snapshots the CHIP-8 framebuffer on request and streams it as 256 byte-wide valid/ready beats.
module chip8_display_scan
  import chip8_pkg::*;
#(
  parameter int unsigned SCREEN_W     = 64,
  parameter int unsigned SCREEN_H     = 32,
  parameter int unsigned FRAME_PERIOD = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SCREEN_W*SCREEN_H-1:0] display_in,
  input  logic                         frame_req,
  output logic                         busy,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_sof,
  output logic                         tx_eol,
  output logic                         tx_eof,
  output logic [15:0]                  frame_count,
  output logic                         req_dropped
);

  scan_state_e                  state_q;
  logic [SCREEN_W*SCREEN_H-1:0] shadow_q;
  logic [7:0]                   beat_q;
  logic [31:0]                  timer_q;
  logic [31:0]                  timer_d;
  logic [15:0]                  frame_count_q;
  logic                         req_dropped_q;

  logic       auto_tick;
  logic       req;
  logic       streaming;
  logic       xfer;
  logic       last_beat;
  logic [7:0] sel_data;

  // Free-running auto-request timer; FRAME_PERIOD of 0 disables it entirely.
  always_comb begin
    auto_tick = 1'b0;
    timer_d   = '0;
    if (FRAME_PERIOD != 0) begin
      auto_tick = (timer_q == FRAME_PERIOD - 1);
      timer_d   = auto_tick ? '0 : timer_q + 32'd1;
    end
  end

  assign req       = frame_req | auto_tick;
  assign streaming = (state_q == SCAN_STREAM);
  assign xfer      = streaming & tx_ready;
  assign last_beat = (beat_q == 8'(BEATS_PER_FRAME - 1));

  chip8_fb_byte_sel u_byte_sel (
    .fb   (shadow_q),
    .beat (beat_q),
    .data (sel_data)
  );

  // Scan state machine, snapshot register and frame bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= SCAN_IDLE;
      shadow_q      <= '0;
      beat_q        <= '0;
      timer_q       <= '0;
      frame_count_q <= '0;
      req_dropped_q <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      req_dropped_q <= 1'b0;
      unique case (state_q)
        SCAN_IDLE: begin
          if (req) begin
            shadow_q <= display_in;
            beat_q   <= '0;
            state_q  <= SCAN_STREAM;
          end
        end
        SCAN_STREAM: begin
          if (xfer) begin
            if (last_beat) begin
              frame_count_q <= frame_count_q + 16'd1;
              beat_q        <= '0;
              // A request landing on the final transfer chains the next frame with no bubble.
              if (req) begin
                shadow_q <= display_in;
              end else begin
                state_q <= SCAN_IDLE;
              end
            end else begin
              beat_q <= beat_q + 8'd1;
            end
          end
          if (req && !(xfer && last_beat)) begin
            req_dropped_q <= 1'b1;
          end
        end
        default: state_q <= SCAN_IDLE;
      endcase
    end
  end

  // Outputs are derived from registered state only, so they hold steady under backpressure.
  always_comb begin
    busy        = streaming;
    tx_valid    = streaming;
    tx_data     = streaming ? sel_data : 8'h00;
    tx_sof      = streaming & (beat_q == 8'd0);
    tx_eol      = streaming & (beat_q[2:0] == 3'(BEATS_PER_ROW - 1));
    tx_eof      = streaming & last_beat;
    frame_count = frame_count_q;
    req_dropped = req_dropped_q;
  end

endmodule

// File: tb/tb_chip8_display_scan.sv
// Directed bench for chip8_display_scan: manual frames, backpressure, isolation, chaining,
// mid-frame reset and the auto-request timer.
module tb_chip8_display_scan;
  import chip8_pkg::*;

  logic          clk;
  logic          reset;
  logic [2047:0] display_in;
  logic          frame_req;
  logic          busy;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    tx_data;
  logic          tx_sof;
  logic          tx_eol;
  logic          tx_eof;
  logic [15:0]   frame_count;
  logic          req_dropped;

  logic          reset_auto;
  logic [2047:0] display_auto;
  logic          req_auto;
  logic          ready_auto;

  logic          a3_busy, a3_valid, a3_sof, a3_eol, a3_eof, a3_drop;
  logic [7:0]    a3_data;
  logic [15:0]   a3_fc;
  logic          a2_busy, a2_valid, a2_sof, a2_eol, a2_eof, a2_drop;
  logic [7:0]    a2_data;
  logic [15:0]   a2_fc;

  int n_checks = 0;
  int n_pass   = 0;
  int drops    = 0;
  int cyc      = 0;
  int a3_sofs  = 0;
  int a3_eofs  = 0;
  int a3_drops = 0;
  int a3_t0    = 0;
  int a3_t1    = 0;
  int a3_te    = 0;
  int a2_sofs  = 0;
  int a2_drops = 0;

  chip8_display_scan #(.FRAME_PERIOD(0)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .display_in  (display_in),
    .frame_req   (frame_req),
    .busy        (busy),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_sof      (tx_sof),
    .tx_eol      (tx_eol),
    .tx_eof      (tx_eof),
    .frame_count (frame_count),
    .req_dropped (req_dropped)
  );

  chip8_display_scan #(.FRAME_PERIOD(300)) u_auto300 (
    .clk         (clk),
    .reset       (reset_auto),
    .display_in  (display_auto),
    .frame_req   (req_auto),
    .busy        (a3_busy),
    .tx_valid    (a3_valid),
    .tx_ready    (ready_auto),
    .tx_data     (a3_data),
    .tx_sof      (a3_sof),
    .tx_eol      (a3_eol),
    .tx_eof      (a3_eof),
    .frame_count (a3_fc),
    .req_dropped (a3_drop)
  );

  chip8_display_scan #(.FRAME_PERIOD(200)) u_auto200 (
    .clk         (clk),
    .reset       (reset_auto),
    .display_in  (display_auto),
    .frame_req   (req_auto),
    .busy        (a2_busy),
    .tx_valid    (a2_valid),
    .tx_ready    (ready_auto),
    .tx_data     (a2_data),
    .tx_sof      (a2_sof),
    .tx_eol      (a2_eol),
    .tx_eof      (a2_eof),
    .frame_count (a2_fc),
    .req_dropped (a2_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (req_dropped) drops <= drops + 1;
    if (a3_drop) a3_drops <= a3_drops + 1;
    if (a2_drop) a2_drops <= a2_drops + 1;
    if (a2_valid && a2_sof) a2_sofs <= a2_sofs + 1;
    if (a3_valid && a3_sof) begin
      if (a3_sofs == 0) a3_t0 <= cyc;
      if (a3_sofs == 1) a3_t1 <= cyc;
      a3_sofs <= a3_sofs + 1;
    end
    if (a3_valid && a3_eof) begin
      if (a3_eofs == 0) a3_te <= cyc;
      a3_eofs <= a3_eofs + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference pixel packing: leftmost pixel of the group in bit 7.
  function automatic logic [7:0] model_byte(input logic [2047:0] fb, input int beat);
    logic [7:0] b;
    int x0, y;
    b  = '0;
    x0 = (beat % 8) * 8;
    y  = beat / 8;
    for (int k = 0; k < 8; k++) begin
      b[7-k] = fb[fb_bit_index(6'(x0 + k), 5'(y))];
    end
    return b;
  endfunction

  task automatic start_frame(input logic [2047:0] fb);
    display_in = fb;
    frame_req  = 1'b1;
    tick();
    frame_req  = 1'b0;
  endtask

  // Consumes one streamed frame from beat 0, comparing every beat against exp_fb.
  task automatic run_frame(input logic [2047:0] exp_fb, input bit stall_rand,
                           input int rewrite_at, input int req_at,
                           input logic [2047:0] new_fb, input bit b2b,
                           output int beats, output int errs, output logic [10:0] last_info);
    logic [7:0] prev_data;
    logic [2:0] prev_flags;
    bit         prev_stall;
    bit         req_done;
    int         cycles;
    beats      = 0;
    errs       = 0;
    cycles     = 0;
    prev_stall = 1'b0;
    req_done   = 1'b0;
    prev_data  = '0;
    prev_flags = '0;
    last_info  = '0;
    while (beats < 256 && cycles < 4000) begin
      tx_ready = stall_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (beats == rewrite_at) display_in = new_fb;
      if (beats == req_at && !req_done) begin
        frame_req = 1'b1;
        req_done  = 1'b1;
      end
      if (b2b && beats == 255 && tx_ready) begin
        display_in = new_fb;
        frame_req  = 1'b1;
      end
      if (tx_valid !== 1'b1 || busy !== 1'b1) errs++;
      if (tx_data !== model_byte(exp_fb, beats)) errs++;
      if (tx_sof !== 1'(beats == 0)) errs++;
      if (tx_eol !== 1'(beats % 8 == 7)) errs++;
      if (tx_eof !== 1'(beats == 255)) errs++;
      if (prev_stall && (tx_data !== prev_data || {tx_sof, tx_eol, tx_eof} !== prev_flags)) errs++;
      if (beats == 255) last_info = {tx_data, tx_sof, tx_eol, tx_eof};
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_flags = {tx_sof, tx_eol, tx_eof};
      if (tx_valid && tx_ready) beats++;
      tick();
      frame_req = 1'b0;
      cycles++;
    end
    tx_ready = 1'b1;
  endtask

  initial begin
    logic [2047:0] fb_a;
    logic [2047:0] fb_b;
    logic [10:0]   last;
    int            beats;
    int            errs;
    int            d0;

    reset        = 1'b0;
    display_in   = '0;
    frame_req    = 1'b0;
    tx_ready     = 1'b1;
    reset_auto   = 1'b0;
    display_auto = '0;
    req_auto     = 1'b0;
    ready_auto   = 1'b1;
    tick();
    tick();
    reset = 1'b1;

    // Reset state.
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_sof", 32'(tx_sof), 32'd0);
    check("rst_fc", 32'(frame_count), 32'd0);
    check("rst_drop", 32'(req_dropped), 32'd0);

    // Single pixel (0,0).
    fb_a    = '0;
    fb_a[0] = 1'b1;
    start_frame(fb_a);
    check("px0_latency_valid", 32'(tx_valid), 32'd1);
    check("px0_beat0_data", 32'(tx_data), 32'h80);
    check("px0_beat0_sof", 32'(tx_sof), 32'd1);
    run_frame(fb_a, 1'b0, -1, -1, '0, 1'b0, beats, errs, last);
    check("px0_beats", 32'(beats), 32'd256);
    check("px0_errs", 32'(errs), 32'd0);
    check("px0_last", 32'(last), {21'd0, 8'h00, 3'b011});
    check("px0_fc", 32'(frame_count), 32'd1);
    check("px0_busy_fall", 32'(busy), 32'd0);
    check("px0_valid_fall", 32'(tx_valid), 32'd0);

    // Single pixel (63,31).
    fb_a       = '0;
    fb_a[2047] = 1'b1;
    start_frame(fb_a);
    run_frame(fb_a, 1'b0, -1, -1, '0, 1'b0, beats, errs, last);
    check("px2047_errs", 32'(errs), 32'd0);
    check("px2047_last", 32'(last), {21'd0, 8'h01, 3'b011});
    check("px2047_fc", 32'(frame_count), 32'd2);

    // Checkerboard with random backpressure.
    for (int i = 0; i < 2048; i++) fb_a[i] = (i % 2 == 0);
    start_frame(fb_a);
    check("cb_beat0_data", 32'(tx_data), 32'hAA);
    run_frame(fb_a, 1'b1, -1, -1, '0, 1'b0, beats, errs, last);
    check("cb_beats", 32'(beats), 32'd256);
    check("cb_errs", 32'(errs), 32'd0);
    check("cb_idle_after", 32'(tx_valid), 32'd0);
    check("cb_fc", 32'(frame_count), 32'd3);

    // Snapshot isolation plus a dropped request.
    for (int i = 0; i < 64; i++) fb_a[i*32 +: 32] = $urandom;
    d0 = drops;
    start_frame(fb_a);
    run_frame(fb_a, 1'b0, 10, 20, {2048{1'b1}}, 1'b0, beats, errs, last);
    check("iso_errs", 32'(errs), 32'd0);
    check("iso_drops", 32'(drops - d0), 32'd1);
    check("iso_fc", 32'(frame_count), 32'd4);

    // Back-to-back frames.
    for (int i = 0; i < 64; i++) fb_a[i*32 +: 32] = $urandom;
    for (int i = 0; i < 64; i++) fb_b[i*32 +: 32] = $urandom;
    d0 = drops;
    start_frame(fb_a);
    run_frame(fb_a, 1'b0, -1, -1, fb_b, 1'b1, beats, errs, last);
    check("b2b_a_errs", 32'(errs), 32'd0);
    check("b2b_valid", 32'(tx_valid), 32'd1);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_sof", 32'(tx_sof), 32'd1);
    check("b2b_data", 32'(tx_data), 32'(model_byte(fb_b, 0)));
    check("b2b_fc_a", 32'(frame_count), 32'd5);
    run_frame(fb_b, 1'b0, -1, -1, '0, 1'b0, beats, errs, last);
    check("b2b_b_errs", 32'(errs), 32'd0);
    check("b2b_fc_b", 32'(frame_count), 32'd6);
    check("b2b_no_drop", 32'(drops - d0), 32'd0);

    // Reset in the middle of a frame.
    start_frame(fb_a);
    tx_ready = 1'b1;
    repeat (100) tick();
    reset = 1'b0;
    tick();
    check("mrst_valid", 32'(tx_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_fc", 32'(frame_count), 32'd0);
    check("mrst_sof", 32'(tx_sof), 32'd0);
    reset = 1'b1;
    tick();
    start_frame(fb_b);
    check("mrst_restart_sof", 32'(tx_sof), 32'd1);
    run_frame(fb_b, 1'b0, -1, -1, '0, 1'b0, beats, errs, last);
    check("mrst_restart_errs", 32'(errs), 32'd0);
    check("mrst_restart_fc", 32'(frame_count), 32'd1);

    // Auto-request timers: 300 never collides, 200 lands mid-frame every other tick.
    for (int i = 0; i < 64; i++) display_auto[i*32 +: 32] = $urandom;
    reset_auto = 1'b1;
    repeat (1300) tick();
    check("a300_sofs", 32'(a3_sofs), 32'd4);
    check("a300_period", 32'(a3_t1 - a3_t0), 32'd300);
    check("a300_frame_len", 32'(a3_te - a3_t0), 32'd255);
    check("a300_drops", 32'(a3_drops), 32'd0);
    check("a300_fc", 32'(a3_fc), 32'd3);
    check("a200_sofs", 32'(a2_sofs), 32'd3);
    check("a200_drops", 32'(a2_drops), 32'd3);
    check("a200_fc", 32'(a2_fc), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
